// File: rtl/adc_buffer_pkg.sv
// Shared types and constants for the ADC ring-buffer producer.
package adc_buffer_pkg;

    // Producer FSM encoding; also visible on the top-level debug port.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_SAMPLE = 2'd1,
        ST_WRITE       = 2'd2
    } adc_state_e;

    // All four byte lanes written for every 32-bit sample.
    localparam logic [3:0] BRAM_WE_ALL = 4'b1111;

    // Width of the dropped/missed sample counter.
    localparam int OVR_CNT_W = 16;

    // Width of one sample / one BRAM word.
    localparam int SAMPLE_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        if (v == {OVR_CNT_W{1'b1}}) begin
            return v;
        end
        return v + OVR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-rate divider: one-cycle tick every (rate_div + 1) enabled cycles.
module adc_tick_gen #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_BITS-1:0] rate_div,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;

    // Next count and tick; '>=' also recovers if rate_div is lowered mid-count.
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (enable) begin
            if (cnt_q >= rate_div) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_BITS'(1);
            end
        end
    end

    // Divider counter register; starts from zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_buffer_producer.sv
// Virtual ADC producer: samples on divider ticks and writes words into a
// BRAM ring buffer, publishing its write pointer to the consumer side.
//
// Handshake: a sample is transferred in any cycle where sample_ready and
// sample_valid are both 1 on the rising edge. sample_ready never depends on
// sample_valid. When the buffer is full the transferred sample is dropped and
// counted as an overrun.
module adc_buffer_producer
    import adc_buffer_pkg::*;
#(
    parameter int ADC_BITS       = 10,
    parameter int BRAM_ADDR_BITS = 32,
    parameter int DIV_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DIV_BITS-1:0]       rate_div,
    input  logic [SAMPLE_W-1:0]       sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [ADC_BITS-1:0]       ADC_buffer_cons_in,
    output logic [ADC_BITS-1:0]       ADC_buffer_prod_out,
    output logic [BRAM_ADDR_BITS-1:0] bram_addr,
    output logic [SAMPLE_W-1:0]       bram_din,
    output logic                      bram_en,
    output logic [3:0]                bram_we,
    output logic                      full,
    output logic                      empty,
    output logic [OVR_CNT_W-1:0]      overrun_count,
    output logic [1:0]                state_dbg
);

    adc_state_e                state_q;
    adc_state_e                state_d;
    logic [ADC_BITS-1:0]       prod_q;
    logic [ADC_BITS-1:0]       prod_d;
    logic [OVR_CNT_W-1:0]      ovr_q;
    logic [OVR_CNT_W-1:0]      ovr_d;
    logic [BRAM_ADDR_BITS-1:0] addr_q;
    logic [BRAM_ADDR_BITS-1:0] addr_d;
    logic [SAMPLE_W-1:0]       din_q;
    logic [SAMPLE_W-1:0]       din_d;
    logic [ADC_BITS-1:0]       prod_inc;
    logic                      tick;
    logic                      ovr_event;

    adc_tick_gen #(
        .DIV_BITS (DIV_BITS)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // Ring status: one slot is kept empty so full and empty are distinct.
    assign prod_inc = prod_q + ADC_BITS'(1);
    assign full     = (prod_inc == ADC_buffer_cons_in);
    assign empty    = (prod_q == ADC_buffer_cons_in);

    assign ADC_buffer_prod_out = prod_q;
    assign bram_addr           = addr_q;
    assign bram_din            = din_q;
    assign overrun_count       = ovr_q;
    assign state_dbg           = state_q;

    // FSM next state, BRAM strobes and overrun accounting.
    // Address and data are loaded at acceptance so they are stable for the
    // whole WRITE cycle and simply hold afterwards.
    always_comb begin
        state_d      = state_q;
        prod_d       = prod_q;
        ovr_d        = ovr_q;
        addr_d       = addr_q;
        din_d        = din_q;
        sample_ready = 1'b0;
        bram_en      = 1'b0;
        bram_we      = '0;
        ovr_event    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_WAIT_SAMPLE;
                end
            end
            ST_WAIT_SAMPLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    sample_ready = 1'b1;
                    if (sample_valid) begin
                        if (full) begin
                            ovr_event = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            addr_d  = BRAM_ADDR_BITS'({prod_q, 2'b00});
                            din_d   = sample_in;
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                bram_en = 1'b1;
                bram_we = BRAM_WE_ALL;
                prod_d  = prod_inc;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick while busy is a missed sample; merged with a full drop.
        if (tick && (state_q != ST_IDLE)) begin
            ovr_event = 1'b1;
        end
        if (ovr_event) begin
            ovr_d = sat_inc(ovr_q);
        end
    end

    // State, pointer, counter and BRAM output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            prod_q  <= '0;
            ovr_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            ovr_q   <= ovr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_adc_buffer_producer.sv
// Self-checking bench for adc_buffer_producer with a tick-schedule model.
module tb_adc_buffer_producer;
    import adc_buffer_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] rate_div;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [9:0]  cons;
    logic [9:0]  prod_out;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic        full;
    logic        empty;
    logic [15:0] overrun_count;
    logic [1:0]  state_dbg;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int          model_prod;
    int          model_ovr;
    int          pend_cyc;
    logic [31:0] exp_q[$];

    adc_buffer_producer #(
        .ADC_BITS       (10),
        .BRAM_ADDR_BITS (32),
        .DIV_BITS       (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .rate_div            (rate_div),
        .sample_in           (sample_in),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .ADC_buffer_cons_in  (cons),
        .ADC_buffer_prod_out (prod_out),
        .bram_addr           (bram_addr),
        .bram_din            (bram_din),
        .bram_en             (bram_en),
        .bram_we             (bram_we),
        .full                (full),
        .empty               (empty),
        .overrun_count       (overrun_count),
        .state_dbg           (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        model_prod = 0;
        model_ovr  = 0;
        pend_cyc   = -1;
        exp_q.delete();
    endtask

    // Assert reset, check reset values, release with enable low.
    task automatic do_reset(input int r, input int c);
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        rate_div     = 16'(r);
        cons         = 10'(c);
        reset        = 1'b0;
        #1;
        check_eq("rst_bram_en", bram_en, 0);
        check_eq("rst_bram_we", bram_we, 0);
        check_eq("rst_bram_addr", bram_addr, 0);
        check_eq("rst_bram_din", bram_din, 0);
        check_eq("rst_prod", prod_out, 0);
        check_eq("rst_overrun", overrun_count, 0);
        check_eq("rst_ready", sample_ready, 0);
        check_eq("rst_empty", empty, (c == 0));
        check_eq("rst_state", state_dbg, ST_IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    // Continuous stream: enable=1, sample_valid=1, random data.
    // Cycle 0 is the first enabled cycle; divider ticks fall on cycles
    // r, 2r+1, ...; each tick's sample is taken the next cycle and written the
    // cycle after that unless the ring is full, in which case it is dropped.
    task automatic run_stream(input int r, input int first, input int last);
        for (int cyc = first; cyc <= last; cyc++) begin
            bit is_acc;
            bit is_wr;
            bit m_full;
            @(posedge clk);
            #1;
            enable       = 1'b1;
            sample_valid = 1'b1;
            sample_in    = $urandom;
            @(negedge clk);
            is_acc = (cyc >= r + 1) && (((cyc - r - 1) % (r + 1)) == 0);
            is_wr  = (pend_cyc == cyc);
            m_full = (((model_prod + 1) % DEPTH) == int'(cons));
            check_eq("prod_out", prod_out, model_prod);
            check_eq("full", full, m_full);
            check_eq("empty", empty, (model_prod == int'(cons)));
            check_eq("overrun", overrun_count, model_ovr);
            check_eq("ready", sample_ready, is_acc);
            check_eq("bram_en", bram_en, is_wr);
            check_eq("bram_we", bram_we, is_wr ? 4'hF : 4'h0);
            if (is_wr) begin
                check_eq("bram_addr", bram_addr, model_prod * 4);
                check_eq("bram_din", bram_din, exp_q.pop_front());
                model_prod = (model_prod + 1) % DEPTH;
            end
            if (is_acc) begin
                if (m_full) begin
                    if (model_ovr < 65535) model_ovr++;
                end else begin
                    pend_cyc = cyc + 1;
                    exp_q.push_back(sample_in);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        rate_div     = '0;
        cons         = '0;

        // Steady stream at rate_div=3: writes every 4 cycles at 0x0, 0x4, ...
        do_reset(3, 0);
        run_stream(3, 0, 40);

        // Randomized rate and consumer position (small cons exercises full).
        for (int it = 0; it < 4; it++) begin
            int r;
            int c;
            r = $urandom_range(2, 6);
            c = $urandom_range(0, 12);
            do_reset(r, c);
            run_stream(r, 0, $urandom_range(60, 150));
        end

        // Fill to full, then one dropped sample.
        do_reset(2, 0);
        run_stream(2, 0, 3074);
        check_eq("full_prod", prod_out, 1023);
        check_eq("full_flag", full, 1);
        check_eq("full_overrun", overrun_count, 1);

        // Consumer moves to 5: one more write at 0xFFC, pointer wraps.
        cons = 10'd5;
        run_stream(2, 3075, 3077);
        check_eq("wrap_prod", prod_out, 0);
        check_eq("wrap_addr", bram_addr, 32'hFFC);
        check_eq("wrap_empty", empty, 0);
        check_eq("wrap_full", full, 0);

        // rate_div=0 with no valid samples: each busy tick is a miss.
        do_reset(0, 0);
        for (int cyc = 0; cyc <= 4; cyc++) begin
            @(posedge clk);
            #1;
            enable       = 1'b1;
            sample_valid = 1'b0;
            sample_in    = $urandom;
            @(negedge clk);
            check_eq("miss_bram_en", bram_en, 0);
            check_eq("miss_overrun", overrun_count, (cyc > 1) ? cyc - 1 : 0);
            check_eq("miss_ready", sample_ready, (cyc >= 1));
        end

        // Reset in the middle of the write with prod=7.
        do_reset(2, 0);
        run_stream(2, 0, 24);
        @(posedge clk);
        #1;
        sample_in = $urandom;
        check_eq("midw_pre_en", bram_en, 1);
        check_eq("midw_pre_prod", prod_out, 7);
        reset = 1'b0;
        #1;
        check_eq("midw_bram_en", bram_en, 0);
        check_eq("midw_bram_we", bram_we, 0);
        check_eq("midw_prod", prod_out, 0);
        check_eq("midw_overrun", overrun_count, 0);
        check_eq("midw_addr", bram_addr, 0);
        @(posedge clk);
        #1;
        check_eq("midw_prod_hold", prod_out, 0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();

        // Drop enable while waiting for a sample.
        do_reset(3, 0);
        for (int cyc = 0; cyc <= 7; cyc++) begin
            @(posedge clk);
            #1;
            enable       = (cyc < 5);
            sample_valid = (cyc >= 5);
            sample_in    = $urandom;
            @(negedge clk);
            check_eq("dis_ready", sample_ready, (cyc == 4));
            check_eq("dis_bram_en", bram_en, 0);
            check_eq("dis_prod", prod_out, 0);
            check_eq("dis_overrun", overrun_count, 0);
            if (cyc >= 6) begin
                check_eq("dis_state", state_dbg, ST_IDLE);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
